// File: rtl/uart_level_fifo.sv
// Level-tracking synchronous FIFO for the UART TX/RX paths: any depth >= 2, occupancy count,
// threshold flags, sticky error flags and flush. Define UART_FIFO_FWFT_EN for first-word-fall-through reads.
module uart_level_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = DEPTH - 2,
  parameter int AEMPTY_LEVEL = 2,
  localparam int LW          = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  write_mode,
  input  logic                  read_mode,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [LW-1:0]         level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0] level_reg, level_next;
  logic          full_reg, empty_reg, afull_reg, aempty_reg;
  logic          overflow_reg, underflow_reg;
  logic          do_flush, rd_ok, wr_ok;

  assign do_flush = enable & flush;
  assign rd_ok    = enable & read_mode & ~empty_reg;
  // When full, a write is still accepted if a read frees the head slot in the same cycle.
  assign wr_ok    = enable & write_mode & (~full_reg | rd_ok);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (do_flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      if (wr_ok)
        wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      if (rd_ok)
        rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
      if (wr_ok && !rd_ok)
        level_next = level_reg + LW'(1);
      else if (rd_ok && !wr_ok)
        level_next = level_reg - LW'(1);
    end
  end

  // Flags are derived from level_next so they change on the same edge as level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      afull_reg     <= 1'b0;
      aempty_reg    <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (enable) begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      full_reg   <= (level_next == LW'(DEPTH));
      empty_reg  <= (level_next == '0);
      afull_reg  <= (level_next >= LW'(AFULL_LEVEL));
      aempty_reg <= (level_next <= LW'(AEMPTY_LEVEL));
      if (do_flush) begin
        overflow_reg  <= 1'b0;
        underflow_reg <= 1'b0;
      end else begin
        if (write_mode && !wr_ok)
          overflow_reg <= 1'b1;
        if (read_mode && empty_reg && !write_mode)
          underflow_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !do_flush)
      mem[wr_ptr_reg] <= data_in;
  end

`ifdef UART_FIFO_FWFT_EN
  assign data_out = mem[rd_ptr_reg];
  assign valid    = ~empty_reg;
`else
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  valid_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
    end else if (!enable || do_flush) begin
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= rd_ok;
      if (rd_ok)
        data_out_reg <= mem[rd_ptr_reg];
    end
  end

  assign data_out = data_out_reg;
  assign valid    = valid_reg;
`endif

  assign level        = level_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = afull_reg;
  assign almost_empty = aempty_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_uart_level_fifo.sv
// Directed bench for uart_level_fifo (DEPTH=6): a queue scoreboard holds expected contents,
// pushed on accepted writes and popped/compared on reads; flags are checked after every step.
module tb_uart_level_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 6;
  localparam int AF    = 5;
  localparam int AE    = 1;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          write_mode = 1'b0;
  logic          read_mode = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [LW-1:0] level;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_dout = '0;

  uart_level_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .write_mode(write_mode), .read_mode(read_mode), .data_in(data_in),
    .data_out(data_out), .valid(valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = q.size();
    chk({tag, ":level"}, 32'(level), 32'(n));
    chk({tag, ":full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ":almost_full"}, 32'(almost_full), 32'(n >= AF));
    chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    chk({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ":underflow"}, 32'(underflow), 32'(m_unf));
`ifdef UART_FIFO_FWFT_EN
    chk({tag, ":valid"}, 32'(valid), 32'(n != 0));
    if (n != 0)
      chk({tag, ":head"}, 32'(data_out), 32'(q[0]));
`else
    chk({tag, ":valid"}, 32'(valid), 32'(m_valid));
    if (m_valid)
      chk({tag, ":data_out"}, 32'(data_out), 32'(m_dout));
`endif
  endtask

  // One clock of stimulus; the scoreboard is updated from the pre-edge model state.
  task automatic step(input string tag, input logic en, input logic wr, input logic rd,
                      input logic fl, input logic [DW-1:0] din);
    logic e_m, f_m, rd_ok, wr_ok;
    enable = en; write_mode = wr; read_mode = rd; flush = fl; data_in = din;
    e_m   = (q.size() == 0);
    f_m   = (q.size() == DEPTH);
    rd_ok = en & rd & ~e_m;
    wr_ok = en & wr & (~f_m | rd_ok);
    @(posedge clk);
    #1;
    if (en && fl) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0;
    end else if (en) begin
      m_valid = rd_ok;
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(din);
      if (wr && !wr_ok) m_ovf = 1'b1;
      if (rd && e_m && !wr) m_unf = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    enable = 1'b0; write_mode = 1'b0; read_mode = 1'b0; flush = 1'b0;
    $display("step %-10s en=%0d wr=%0d rd=%0d fl=%0d din=%02h -> level=%0d valid=%0d dout=%02h ovf=%0d unf=%0d",
             tag, en, wr, rd, fl, din, level, valid, data_out, overflow, underflow);
    check_state(tag);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
`ifndef UART_FIFO_FWFT_EN
    chk("reset:data_out", 32'(data_out), 32'h0);
`endif
    reset = 1'b0;

    // Fill 0x11..0x16, then a rejected 7th write
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 1, 0, 0, 8'(8'h11 + i));
    step("overfill", 1, 1, 0, 0, 8'h17);

    // Drain in order, then a read on empty
    for (int i = 0; i < DEPTH; i++) step("drain", 1, 0, 1, 0, 8'h00);
    step("underrd", 1, 0, 1, 0, 8'h00);

    // Wrap-around: write 4, read 4, write 6, read 6
    step("flush0", 1, 0, 0, 1, 8'h00);
    for (int i = 0; i < 4; i++) step("wrap_w4", 1, 1, 0, 0, 8'(8'h21 + i));
    for (int i = 0; i < 4; i++) step("wrap_r4", 1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 6; i++) step("wrap_w6", 1, 1, 0, 0, 8'(8'h31 + i));
    for (int i = 0; i < 6; i++) step("wrap_r6", 1, 0, 1, 0, 8'h00);

    // Simultaneous read+write when full, then when empty
    for (int i = 0; i < DEPTH; i++) step("fill2", 1, 1, 0, 0, 8'(8'h11 + i));
    step("rw_full", 1, 1, 1, 0, 8'h17);
    for (int i = 0; i < DEPTH; i++) step("drain2", 1, 0, 1, 0, 8'h00);
    step("rw_empty", 1, 1, 1, 0, 8'h20);
    step("rd_one", 1, 0, 1, 0, 8'h00);

    // Level 3 with overflow set; disabled requests are ignored; flush discards the write
    for (int i = 0; i < DEPTH; i++) step("fill3", 1, 1, 0, 0, 8'(8'h51 + i));
    step("ovf3", 1, 1, 0, 0, 8'h57);
    for (int i = 0; i < 3; i++) step("to_lvl3", 1, 0, 1, 0, 8'h00);
    step("en0_wr", 0, 1, 0, 0, 8'h99);
    step("en0_rd", 0, 0, 1, 0, 8'h00);
    step("en0_fl", 0, 1, 1, 1, 8'h98);
    step("flush_wr", 1, 1, 0, 1, 8'h77);
    step("post_fl", 1, 0, 1, 0, 8'h00);

    // Asynchronous reset mid-burst at level 4
    for (int i = 0; i < 4; i++) step("burst", 1, 1, 0, 0, 8'(8'h61 + i));
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0; m_dout = '0;
    check_state("async_rst");
`ifndef UART_FIFO_FWFT_EN
    chk("async_rst:data_out", 32'(data_out), 32'h0);
`endif
    #3;
    reset = 1'b0;
    step("resume_w", 1, 1, 0, 0, 8'h41);
    step("resume_r", 1, 0, 1, 0, 8'h00);
    step("idle", 1, 0, 0, 0, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_level_fifo.md
# uart_level_fifo

Parametrised synchronous FIFO used as the TX and RX buffer between the UART byte engines and the host register interface. It generalises the simple FIFO used elsewhere: arbitrary (non-power-of-two) depth, an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. An optional first-word-fall-through read mode is available at compile time.

## Interface
- DATA_WIDTH, 8, width of each stored word
- DEPTH, 16, number of entries; any value ≥ 2, not restricted to powers of two
- AFULL_LEVEL, DEPTH-2, almost_full asserts when level ≥ this value; range 1..DEPTH
- AEMPTY_LEVEL, 2, almost_empty asserts when level ≤ this value; range 0..DEPTH-1
- Derived LW = $clog2(DEPTH+1), the level width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  global qualifier; when low, no writes, reads, flushes or error updates occur
- flush  in  1  synchronous clear of contents and error flags
- write_mode  in  1  write request
- read_mode  in  1  read request
- data_in  in  DATA_WIDTH  write data
- data_out  out  DATA_WIDTH  read data
- valid  out  1  data_out qualifier
- full, empty  out  1 each  occupancy flags
- almost_full, almost_empty  out  1 each  threshold flags
- level  out  LW  current number of stored words, 0..DEPTH
- overflow, underflow  out  1 each  sticky error flags

## Operation
- Storage: DEPTH × DATA_WIDTH array. Read and write pointers run 0..DEPTH-1 and wrap from DEPTH-1 to 0 by explicit compare, not modulo of a power of two.
- Occupancy: level is an explicit counter. full = (level == DEPTH), empty = (level == 0), almost_full = (level ≥ AFULL_LEVEL), almost_empty = (level ≤ AEMPTY_LEVEL). All flags are registered and consistent with level in the same cycle.
- Accepted write (wr_ok) = enable & write_mode & (!full | rd_ok).
- Accepted read (rd_ok) = enable & read_mode & !empty.
- Simultaneous read and write:
  - When full, both are accepted and level is unchanged.
  - When empty, only the write is accepted. The read is rejected, and this is not an underflow.
  - Otherwise both pointers advance and level is unchanged.
- Error flags:
  - overflow sets on enable & write_mode & !wr_ok.
  - underflow sets on enable & read_mode & empty & !write_mode.
  - Both flags are sticky until flush or reset.
- Flush (enable & flush) has priority over reads and writes in the same cycle. It zeroes both pointers and level, sets empty and almost_empty (almost_empty only if AEMPTY_LEVEL ≥ 0, which always holds), clears the error flags and drives valid to 0. Memory contents are not cleared.
- When enable is low, all state holds. In non-FWFT mode valid goes to 0.

## Timing
- Reset values:
  - pointers 0, level 0
  - empty 1, full 0
  - almost_empty 1; almost_full 0
  - overflow 0, underflow 0
  - valid 0, data_out 0
- Write accepted at edge N: the word becomes readable from edge N+1 onward, and the flags and level reflect it after edge N.
- Non-FWFT read accepted at edge N: data_out takes mem[rd_ptr] and valid = 1 after edge N, for one cycle. valid returns to 0 after the next edge unless another read is accepted.
- Back-to-back reads produce one word per cycle, with valid held high.
- Reset asserted mid-operation clears state immediately, without waiting for clk. Operation resumes on the first edge after reset is deasserted.

## Configuration
- Macro UART_FIFO_FWFT_EN selects the read mode.
- Defined (first-word-fall-through):
  - data_out always presents the head word mem[rd_ptr].
  - valid = !empty, so valid reflects the head.
  - An accepted read pops the head, and the next word appears after that edge.
  - Read latency is 0, and after the first write to an empty FIFO the data is visible one cycle after the write edge.
- Undefined: the registered one-cycle read latency described under Timing.

## Test plan
- DEPTH=6, AFULL_LEVEL=5, AEMPTY_LEVEL=1. Write 0x11..0x16 on consecutive cycles.
  - Expect level 1..6.
  - almost_empty drops at level 2 and almost_full rises at level 5.
  - full = 1 after the 6th write.
  - A 7th write of 0x17 sets overflow, and level stays 6.
- From full, read 6 times (non-FWFT). Expect data_out 0x11..0x16 with valid high on the cycle after each read edge, then empty = 1. A further read sets underflow, and valid stays 0.
- Wrap-around: write 4, read 4, write 6, read 6. Expect data in FIFO order and pointers wrapping 5 → 0 without loss.
- Simultaneous read+write when full: level stays 6, the head 0x11 is output, 0x17 is stored, and overflow stays 0. When empty, the write is accepted, level becomes 1, valid = 0, and underflow stays 0.
- Flush with write_mode=1 at level 3 with overflow set: expect level 0, empty 1, overflow 0, and the write discarded. With enable=0, requests are ignored and the flags are unchanged.
- Assert reset asynchronously mid-burst at level 4: all outputs reach their reset values before the next clk edge.
- Repeat the first two scenarios with UART_FIFO_FWFT_EN defined: data_out = 0x11 the cycle after the first write, with valid = !empty.
